shtp_rx_framer: RTL
===================

// Module: shtp_rx_framer
// PURPOSE
//  Receive-side SHTP framer. Sits between the SPI byte engine and the sensor-report decoder.
//  - Parses the 4-byte SHTP header from the incoming byte stream.
//  - Buffers the payload in a single on-chip packet buffer.
//  - Presents one complete packet at a time to the decoder via a valid/ack handshake and a read port.
// PARAMETERS
//  MAX_PAYLOAD  128  payload buffer depth in bytes (power of 2, >=16)
//  ADDR_W       $clog2(MAX_PAYLOAD)  buffer address width
// PORTS
//  clk           in   1    system clock, all logic on posedge
//  rst_n         in   1    asynchronous active-low reset
//  frame_active  in   1    high while SPI chip-select asserted; falling edge ends frame
//  byte_valid    in   1    one received byte on byte_data this cycle
//  byte_data     in   8    received byte
//  pkt_valid     out  1    complete packet held in buffer
//  pkt_channel   out  8    header channel of held packet
//  pkt_seq       out  8    header sequence number of held packet
//  pkt_len       out  15   payload length in bytes (header length - 4)
//  pkt_cont      out  1    header bit 15 (continuation) of held packet
//  rd_addr       in   ADDR_W  payload read address
//  rd_data       out  8    payload byte; 1-cycle synchronous read latency
//  pkt_ack       in   1    decoder done; releases buffer
//  drop_count    out  8    saturating count of dropped packets
//  seq_error     out  1    sticky sequence-gap flag (SHTP_SEQ_CHECK_EN only, else 0)
// BEHAVIOUR
//  Reset: state IDLE; pkt_valid=0, pkt_channel/seq/len/cont=0, drop_count=0, seq_error=0, rd_data=0.
//  FSM: IDLE -> HDR -> PAYLOAD -> HOLD -> IDLE; plus DRAIN.
//  - IDLE: first byte_valid while frame_active = header byte 0 -> HDR (hdr_idx=1).
//  - HDR: bytes 1..3 latch len MSB, channel, seq. At byte 3: total={b1[6:0],b0}.
//    - total<=4: packet empty, no pkt_valid, no drop -> DRAIN.
//    - total-4 > MAX_PAYLOAD: drop_count++ -> DRAIN.
//    - else -> PAYLOAD, wr_ptr=0.
//  - PAYLOAD: each byte_valid writes buf[wr_ptr], wr_ptr++. On the byte making wr_ptr==total-4:
//    pkt_valid=1 the NEXT cycle; outputs latched; -> HOLD.
//  - HOLD: pkt_valid stays 1 and pkt_* fields are stable until pkt_ack is sampled high.
//    Then pkt_valid=0 the next cycle -> IDLE.
//    - byte_valid in HOLD (buffer busy): new header is still parsed in a shadow counter.
//      The packet is dropped whole (drop_count++ once per packet) and the held packet is untouched.
//  - DRAIN: discards bytes until frame_active falls -> IDLE.
//  Frame end: frame_active low in HDR/PAYLOAD aborts. drop_count++ only if header was complete.
//    Abort goes to IDLE; buffer contents are don't-care.
//  Simultaneous events: pkt_ack and the first byte of a new frame in the same cycle.
//    The byte is dropped; the frame is counted as a drop.
//  pkt_ack outside HOLD is ignored.
//  drop_count saturates at 8'hFF and never wraps.
//  Buffer read is valid at any time; content only guaranteed while pkt_valid=1.
//  Reset mid-packet: immediate return to reset values; partial packet discarded, not counted.
// CONFIGURATION
//  SHTP_SEQ_CHECK_EN defined: keeps an 8-bit expected seq per channel 0..5.
//  - On each delivered packet, seq != expected (after the first packet on that channel)
//    sets seq_error (sticky until reset).
//  - Expected <= seq+1 (mod 256). Channels >5 are not checked.
//  Undefined: no per-channel state; seq_error tied 0.
// TESTING
//  Bytes 0C 00 03 07 + 8 payload bytes 01..08 -> pkt_valid 1 cycle after last byte.
//    Expect ch=3, seq=7, len=8, cont=0; rd_addr 0..7 returns 01..08; pkt_ack -> pkt_valid=0 next cycle.
//  Header 04 00 02 00, then frame_active low -> no pkt_valid, drop_count unchanged, FSM IDLE.
//  Header 85 00 (total=0x85=133, payload 129 > 128) -> drop_count=1, no pkt_valid, DRAIN until frame end.
//  frame_active falls after 3 of 8 payload bytes -> drop_count +1, IDLE; next valid packet delivered.
//  Second full packet sent while first held (no ack) -> first packet fields/data unchanged, drop_count +1.
//  SHTP_SEQ_CHECK_EN: ch 3 seq 7 then ch 3 seq 9 -> seq_error=1 after second pkt_valid.
//    With seq 8 instead -> seq_error stays 0.

Source files
------------

// File: rtl/shtp_rx_framer.sv
// shtp_rx_framer: SHTP receive framer; header parse, single packet buffer, valid/ack delivery.
// Optional per-channel sequence gap detection is compiled in with `define SHTP_SEQ_CHECK_EN.
module shtp_rx_framer #(
    parameter int MAX_PAYLOAD = 128,
    parameter int ADDR_W      = $clog2(MAX_PAYLOAD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_active,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              pkt_valid,
    output logic [7:0]        pkt_channel,
    output logic [7:0]        pkt_seq,
    output logic [14:0]       pkt_len,
    output logic              pkt_cont,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              pkt_ack,
    output logic [7:0]        drop_count,
    output logic              seq_error
);
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, HOLD, DRAIN} state_t;
    state_t      state_q;
    logic [2:0]  hdr_idx_q;
    logic [7:0]  b0_q, b1_q, ch_q, seq_q;
    logic [14:0] plen_q, wr_cnt_q, total_d;
    logic [7:0]  drop_q, drop_count_d;
    logic        pkt_valid_q, pkt_cont_q;
    logic [7:0]  pkt_channel_q, pkt_seq_q, rd_data_q;
    logic [14:0] pkt_len_q;
    logic        wr_en;
    logic [7:0]  mem [MAX_PAYLOAD];
`ifdef SHTP_SEQ_CHECK_EN
    logic [7:0]  exp_q [8];
    logic [7:0]  seen_q;
    logic        seq_err_q;
`endif

    // Header total length, saturating drop increment and buffer write strobe.
    always_comb begin
        total_d      = {b1_q[6:0], b0_q};
        drop_count_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        wr_en        = (state_q == PAYLOAD) && frame_active && byte_valid;
    end

    // Framing FSM; in HOLD the header fields double as a shadow parser for frames that must be dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hdr_idx_q     <= 3'd0;
            b0_q          <= 8'd0;
            b1_q          <= 8'd0;
            ch_q          <= 8'd0;
            seq_q         <= 8'd0;
            plen_q        <= 15'd0;
            wr_cnt_q      <= 15'd0;
            drop_q        <= 8'd0;
            pkt_valid_q   <= 1'b0;
            pkt_channel_q <= 8'd0;
            pkt_seq_q     <= 8'd0;
            pkt_len_q     <= 15'd0;
            pkt_cont_q    <= 1'b0;
`ifdef SHTP_SEQ_CHECK_EN
            for (int i = 0; i < 8; i++) exp_q[i] <= 8'd0;
            seen_q        <= 8'd0;
            seq_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (frame_active && byte_valid) begin
                    b0_q      <= byte_data;
                    hdr_idx_q <= 3'd1;
                    state_q   <= HDR;
                end
                HDR: if (!frame_active) begin
                    state_q <= IDLE;
                end else if (byte_valid) begin
                    hdr_idx_q <= hdr_idx_q + 3'd1;
                    if (hdr_idx_q == 3'd1) b1_q <= byte_data;
                    else if (hdr_idx_q == 3'd2) ch_q <= byte_data;
                    else begin
                        seq_q    <= byte_data;
                        wr_cnt_q <= 15'd0;
                        plen_q   <= total_d - 15'd4;
                        if (total_d <= 15'd4) state_q <= DRAIN;
                        else if (total_d - 15'd4 > 15'(MAX_PAYLOAD)) begin
                            drop_q  <= drop_count_d;
                            state_q <= DRAIN;
                        end else state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: if (!frame_active) begin
                    drop_q  <= drop_count_d;
                    state_q <= IDLE;
                end else if (byte_valid) begin
                    wr_cnt_q <= wr_cnt_q + 15'd1;
                    if (wr_cnt_q + 15'd1 == plen_q) begin
                        pkt_valid_q   <= 1'b1;
                        pkt_channel_q <= ch_q;
                        pkt_seq_q     <= seq_q;
                        pkt_len_q     <= plen_q;
                        pkt_cont_q    <= b1_q[7];
                        hdr_idx_q     <= 3'd0;
                        state_q       <= HOLD;
`ifdef SHTP_SEQ_CHECK_EN
                        if (ch_q < 8'd6) begin
                            if (seen_q[ch_q[2:0]] && seq_q != exp_q[ch_q[2:0]]) seq_err_q <= 1'b1;
                            exp_q[ch_q[2:0]]  <= seq_q + 8'd1;
                            seen_q[ch_q[2:0]] <= 1'b1;
                        end
`endif
                    end
                end
                HOLD: if (pkt_ack) begin
                    pkt_valid_q <= 1'b0;
                    hdr_idx_q   <= 3'd0;
                    if (frame_active && (byte_valid || hdr_idx_q != 3'd0)) begin
                        state_q <= DRAIN;
                        if (hdr_idx_q < 3'd4) drop_q <= drop_count_d;
                    end else state_q <= IDLE;
                end else if (!frame_active) begin
                    hdr_idx_q <= 3'd0;
                end else if (byte_valid && hdr_idx_q < 3'd4) begin
                    hdr_idx_q <= hdr_idx_q + 3'd1;
                    if (hdr_idx_q == 3'd0) b0_q <= byte_data;
                    else if (hdr_idx_q == 3'd1) b1_q <= byte_data;
                    else if (hdr_idx_q == 3'd3 && total_d > 15'd4) drop_q <= drop_count_d;
                end
                DRAIN: if (!frame_active) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt_q[ADDR_W-1:0]] <= byte_data;
    end

    // Registered read port, one cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= 8'd0;
        else rd_data_q <= mem[rd_addr];
    end

    assign pkt_valid   = pkt_valid_q;
    assign pkt_channel = pkt_channel_q;
    assign pkt_seq     = pkt_seq_q;
    assign pkt_len     = pkt_len_q;
    assign pkt_cont    = pkt_cont_q;
    assign rd_data     = rd_data_q;
    assign drop_count  = drop_q;
`ifdef SHTP_SEQ_CHECK_EN
    assign seq_error   = seq_err_q;
`else
    assign seq_error   = 1'b0;
`endif
endmodule
